serial_adder: RTL and testbench

- Bit-serial N-bit adder built around one full-adder cell and a carry flip-flop.
- Accepts two operands and a carry-in through a valid/ready handshake.
- Adds one bit per clock, LSB first, and presents the N-bit sum and final carry through a valid/ready output handshake.
- Sits directly upstream of the full-adder cell: it sequences operand bits into the cell, feeds the registered carry back, and collects the cell's sum/carry outputs.

---
 rtl/serial_adder.sv | 140 ++++++++++++++
 tb/tb_serial_adder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: a single full-adder cell and a carry flop, one bit per clock, LSB first.
// Operands enter and the sum leaves through valid/ready handshakes.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum_c,
  output logic carry_c
);

  assign sum_c   = a ^ b ^ ci;
  assign carry_c = (a & b) | (a & ci) | (b & ci);

endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             c;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum_c;
  logic             fa_carry_c;
  logic [WIDTH-1:0] sum_next_c;
  logic             last_bit_c;
  logic             unused_sum_lsb;

  full_adder_cell u_fa (
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .ci      (c),
    .sum_c   (fa_sum_c),
    .carry_c (fa_carry_c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_next_c = fa_sum_c;
    end else begin : g_sum_wn
      assign sum_next_c = {fa_sum_c, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  // The oldest bit of the shift register is always shifted out, never read.
  assign unused_sum_lsb = sum_sh[0];

  assign last_bit_c = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            c        <= cin;
            cnt      <= '0;
            sum_sh   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          c      <= fa_carry_c;
          sum_sh <= sum_next_c;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          if (last_bit_c) begin
            // Publish the completed result together with out_valid.
            sum       <= sum_next_c;
            carry_out <= fa_carry_c;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for handshake/timing scenarios
// and a 1-bit instance for the full-adder truth table.

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       out_valid8;
  logic       out_ready8 = 1'b1;
  logic [7:0] sum8;
  logic       carry8;
  logic       busy8;

  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       out_valid1;
  logic       out_ready1 = 1'b1;
  logic [0:0] sum1;
  logic       carry1;
  logic       busy1;

  int tests = 0;
  int fails = 0;

  logic [8:0] sb8[$];
  logic [1:0] sb1[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry_out(carry8), .busy(busy8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .carry_out(carry1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; expected result goes to the scoreboard at the accept edge.
  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input string name);
    int n;
    logic done;
    in_valid8 = 1'b1;
    a8 = av;
    b8 = bv;
    cin8 = cv;
    n = 0;
    done = 1'b0;
    while (!done && n < 50) begin
      if (in_ready8) begin
        sb8.push_back({1'b0, av} + {1'b0, bv} + 9'(cv));
        done = 1'b1;
      end
      tick();
      n++;
    end
    in_valid8 = 1'b0;
    // Operands were captured at acceptance; scramble the bus to prove it.
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    cin8 = 1'($urandom);
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s accept timeout: in_ready never seen", name);
    end
  endtask

  // Wait for out_valid, check latency and result; with out_ready=1 the result is consumed.
  task automatic recv8(input string name);
    int n;
    logic [8:0] exp;
    n = 0;
    while (!out_valid8 && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 8) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles, expected 8", name, n);
    end
    exp = (sb8.size() > 0) ? sb8.pop_front() : 9'h1ff;
    tests++;
    if ({carry8, sum8} !== exp) begin
      fails++;
      $display("FAIL %s result: got {c,sum}=%h, expected %h", name, {carry8, sum8}, exp);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests++;
    if ({in_ready8, out_valid8, busy8, carry8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL reset8: got rdy=%b vld=%b busy=%b c=%b sum=%h, expected 1 0 0 0 00",
               in_ready8, out_valid8, busy8, carry8, sum8);
    end
    tests++;
    if ({in_ready1, out_valid1, busy1, carry1, sum1} !== 5'b10000) begin
      fails++;
      $display("FAIL reset1: got %b, expected 10000", {in_ready1, out_valid1, busy1, carry1, sum1});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    out_ready8 = 1'b1;
    send8(8'h00, 8'h00, 1'b0, "zero");
    tests++;
    if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
      fails++;
      $display("FAIL run_flags: got busy=%b in_ready=%b, expected 1 0", busy8, in_ready8);
    end
    recv8("zero");
    send8(8'hFF, 8'h01, 1'b0, "ff_01");
    recv8("ff_01");
    send8(8'hFF, 8'hFF, 1'b1, "ff_ff_1");
    recv8("ff_ff_1");
    send8(8'h5A, 8'h33, 1'b1, "5a_33_1");
    recv8("5a_33_1");
  endtask

  task automatic test_backpressure();
    logic [8:0] exp;
    int n;
    out_ready8 = 1'b0;
    send8(8'hC3, 8'h7E, 1'b0, "bp");
    n = 0;
    while (!out_valid8 && n < 50) begin
      tick();
      n++;
    end
    exp = (sb8.size() > 0) ? sb8.pop_front() : 9'h1ff;
    for (int i = 0; i < 5; i++) begin
      in_valid8 = i[0];
      a8 = 8'($urandom);
      tests++;
      if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || {carry8, sum8} !== exp) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b {c,sum}=%h, expected 1 0 %h",
                 i, out_valid8, in_ready8, {carry8, sum8}, exp);
      end
      tick();
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick();
    tests++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: got vld=%b rdy=%b busy=%b, expected 0 1 0",
               out_valid8, in_ready8, busy8);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    int n;
    out_ready8 = 1'b1;
    in_valid8 = 1'b1;
    a8 = 8'h81; b8 = 8'h9C; cin8 = 1'b1;
    sb8.push_back({1'b0, 8'h81} + {1'b0, 8'h9C} + 9'd1);
    tick();
    // Second operand waits on the bus with in_valid still high.
    a8 = 8'h3C; b8 = 8'h2B; cin8 = 1'b0;
    sb8.push_back({1'b0, 8'h3C} + {1'b0, 8'h2B});
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!out_valid8 && n < 50) begin
        tick();
        n++;
      end
      tests++;
      if (n !== 8) begin
        fails++;
        $display("FAIL b2b[%0d] latency: got %0d, expected 8", k, n);
      end
      exp = (sb8.size() > 0) ? sb8.pop_front() : 9'h1ff;
      tests++;
      if ({carry8, sum8} !== exp) begin
        fails++;
        $display("FAIL b2b[%0d] result: got %h, expected %h", k, {carry8, sum8}, exp);
      end
      tick();
      if (k == 0) begin
        tests++;
        if (in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
          fails++;
          $display("FAIL b2b idle: got rdy=%b busy=%b, expected 1 0", in_ready8, busy8);
        end
        tick();
        in_valid8 = 1'b0;
        tests++;
        if (busy8 !== 1'b1 || in_ready8 !== 1'b0) begin
          fails++;
          $display("FAIL b2b accept: got busy=%b rdy=%b, expected 1 0", busy8, in_ready8);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    send8(8'hAA, 8'h11, 1'b0, "rst_run");
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    void'(sb8.pop_front());
    tests++;
    if ({in_ready8, out_valid8, busy8, carry8, sum8} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL rst_mid: got rdy=%b vld=%b busy=%b c=%b sum=%h, expected 1 0 0 0 00",
               in_ready8, out_valid8, busy8, carry8, sum8);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send8(8'h96, 8'h6A, 1'b1, "after_rst");
    recv8("after_rst");
  endtask

  task automatic test_width1();
    logic [1:0] exp;
    logic [2:0] v;
    int n;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[0];
      b1 = v[1];
      cin1 = v[2];
      in_valid1 = 1'b1;
      n = 0;
      while (!in_ready1 && n < 20) begin
        tick();
        n++;
      end
      sb1.push_back(2'(v[0]) + 2'(v[1]) + 2'(v[2]));
      tick();
      in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 20) begin
        tick();
        n++;
      end
      exp = (sb1.size() > 0) ? sb1.pop_front() : 2'bxx;
      tests++;
      if (n !== 1 || {carry1, sum1} !== exp) begin
        fails++;
        $display("FAIL w1[a=%b b=%b ci=%b]: got {c,s}=%b after %0d cycles, expected %b after 1",
                 v[0], v[1], v[2], {carry1, sum1}, n, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
